// File: rtl/vga_grid_renderer.sv
// Grid renderer for a VGA scan: tracks the cell under the beam with
// counters, fetches the cell status one cycle after publishing the address,
// and composes cursor, grid lines and per-cell shapes into an RGB444 pixel.
// Fixed 3-cycle latency from pixel coordinates to color_out.
module vga_grid_renderer #(
  parameter int          COLS       = 8,
  parameter int          ROWS       = 8,
  parameter int          CELL_W     = 80,
  parameter int          CELL_H     = 60,
  parameter int          LINE_HALF  = 2,
  parameter int          CUR_HALF   = 5,
  parameter int          CROSS_T    = 3,
  parameter logic [95:0] PALETTE    = {12'hFFF, 12'hF80, 12'h888, 12'h0FF,
                                       12'hF0F, 12'hFF0, 12'h0F0, 12'h000},
  parameter logic [15:0] SHAPE      = {2'd1, 2'd3, 2'd2, 2'd1,
                                       2'd2, 2'd3, 2'd1, 2'd0},
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] LINE_COLOR = 12'h00F,
  parameter logic [11:0] CUR_COLOR  = 12'hF00
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic [9:0]  pix_x_in,
  input  logic [9:0]  pix_y_in,
  input  logic [9:0]  cursor_x_in,
  input  logic [9:0]  cursor_y_in,
  output logic [3:0]  cell_x_out,
  output logic [3:0]  cell_y_out,
  input  logic [2:0]  status_in,
  output logic [11:0] color_out,
  output logic        sync_err_out
);

  localparam logic [9:0] COLS_L = 10'(COLS);
  localparam logic [9:0] ROWS_L = 10'(ROWS);
  localparam logic [9:0] CW_M1  = 10'(CELL_W - 1);
  localparam logic [9:0] CH_M1  = 10'(CELL_H - 1);
  localparam logic [9:0] LH_L   = 10'(LINE_HALF);
  localparam logic [9:0] XL_HI  = 10'(CELL_W - LINE_HALF + 1);
  localparam logic [9:0] YL_HI  = 10'(CELL_H - LINE_HALF + 1);
  localparam logic [9:0] CT_L   = 10'(CROSS_T);
  localparam logic [9:0] XF_HI  = 10'(CELL_W - CROSS_T);
  localparam logic [9:0] YF_HI  = 10'(CELL_H - CROSS_T);
  localparam logic [10:0] CUR_L = 11'(CUR_HALF);
  localparam logic signed [15:0] CW_S = 16'(CELL_W);
  localparam logic signed [15:0] CH_S = 16'(CELL_H);
  localparam logic signed [15:0] WH_S = 16'(CELL_W * CELL_H);
  localparam logic signed [15:0] TW_S = 16'(CROSS_T * CELL_W);

  // scan tracking state
  logic [9:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [9:0] ox_q, ox_d, cx_q, cx_d, oy_q, oy_d, cy_q, cy_d;
  logic       x_sync_q, x_sync_d, y_sync_q, y_sync_d;
  logic       bad_q, bad_d, err_q, err_d;
  logic [3:0] cell_x_q, cell_x_d, cell_y_q, cell_y_d;
  logic       x_err, y_err;

  // stage 1: pixel context aligned with the counters
  logic       s1_en_q, s1_en_d, s1_blank_q, s1_blank_d;
  logic [9:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [9:0] s1_curx_q, s1_curx_d, s1_cury_q, s1_cury_d;

  // stage 2: geometry flags waiting for the status lookup
  logic s2_en_q, s2_en_d, s2_blank_q, s2_blank_d, s2_oog_q, s2_oog_d;
  logic s2_cur_q, s2_cur_d, s2_line_q, s2_line_d;
  logic s2_cross_q, s2_cross_d, s2_frame_q, s2_frame_d;

  logic [11:0] color_q, color_d;

  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady;
  logic signed [15:0] ox_s, oy_s, d1, d2, a1, a2;
  logic               vline, hline;
  logic [1:0]         shape;
  logic [11:0]        pal;

  // cell counters: reload on coordinate zero, advance on +1 steps, flag jumps
  always_comb begin
    ox_d     = ox_q;
    cx_d     = cx_q;
    oy_d     = oy_q;
    cy_d     = cy_q;
    x_sync_d = x_sync_q;
    y_sync_d = y_sync_q;
    x_err    = 1'b0;
    y_err    = 1'b0;
    prev_x_d = pix_x_in;
    prev_y_d = pix_y_in;
    if (pix_x_in == 10'd0) begin
      ox_d     = '0;
      cx_d     = '0;
      x_sync_d = 1'b1;
    end else if (enable_in && x_sync_q) begin
      if (pix_x_in == prev_x_q + 10'd1) begin
        if (ox_q == CW_M1) begin
          ox_d = '0;
          cx_d = cx_q + 10'd1;
        end else begin
          ox_d = ox_q + 10'd1;
        end
      end else begin
        x_err = 1'b1;
      end
    end
    if (pix_y_in == 10'd0) begin
      oy_d     = '0;
      cy_d     = '0;
      y_sync_d = 1'b1;
    end else if (y_sync_q && (pix_y_in != prev_y_q)) begin
      if (pix_y_in == prev_y_q + 10'd1) begin
        if (oy_q == CH_M1) begin
          oy_d = '0;
          cy_d = cy_q + 10'd1;
        end else begin
          oy_d = oy_q + 10'd1;
        end
      end else if (enable_in) begin
        y_err = 1'b1;
      end
    end
    // a jump blanks the rest of the line; the flag itself never self-clears
    bad_d    = ((pix_x_in == 10'd0) ? 1'b0 : bad_q) | x_err | y_err;
    err_d    = err_q | x_err | y_err;
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    if ((cx_d < COLS_L) && (cy_d < ROWS_L)) begin
      cell_x_d = cx_d[3:0];
      cell_y_d = cy_d[3:0];
    end
    s1_en_d    = enable_in;
    s1_blank_d = bad_d | ~x_sync_d | ~y_sync_d;
    s1_x_d     = pix_x_in;
    s1_y_d     = pix_y_in;
    s1_curx_d  = cursor_x_in;
    s1_cury_d  = cursor_y_in;
  end

  // tracking and stage-1 registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prev_x_q <= '0; prev_y_q <= '0;
      ox_q <= '0; cx_q <= '0; oy_q <= '0; cy_q <= '0;
      x_sync_q <= 1'b0; y_sync_q <= 1'b0;
      bad_q <= 1'b0; err_q <= 1'b0;
      cell_x_q <= '0; cell_y_q <= '0;
      s1_en_q <= 1'b0; s1_blank_q <= 1'b0;
      s1_x_q <= '0; s1_y_q <= '0; s1_curx_q <= '0; s1_cury_q <= '0;
    end else begin
      prev_x_q <= prev_x_d; prev_y_q <= prev_y_d;
      ox_q <= ox_d; cx_q <= cx_d; oy_q <= oy_d; cy_q <= cy_d;
      x_sync_q <= x_sync_d; y_sync_q <= y_sync_d;
      bad_q <= bad_d; err_q <= err_d;
      cell_x_q <= cell_x_d; cell_y_q <= cell_y_d;
      s1_en_q <= s1_en_d; s1_blank_q <= s1_blank_d;
      s1_x_q <= s1_x_d; s1_y_q <= s1_y_d; s1_curx_q <= s1_curx_d; s1_cury_q <= s1_cury_d;
    end
  end

  // geometry: cursor distance, grid lines and both shape masks
  always_comb begin
    dx   = $signed({1'b0, s1_x_q}) - $signed({1'b0, s1_curx_q});
    dy   = $signed({1'b0, s1_y_q}) - $signed({1'b0, s1_cury_q});
    adx  = (dx < 0) ? 11'(-dx) : 11'(dx);
    ady  = (dy < 0) ? 11'(-dy) : 11'(dy);
    ox_s = $signed({6'd0, ox_q});
    oy_s = $signed({6'd0, oy_q});
    d1   = ox_s * CH_S - oy_s * CW_S;
    d2   = ox_s * CH_S + oy_s * CW_S - WH_S;
    a1   = (d1 < 0) ? -d1 : d1;
    a2   = (d2 < 0) ? -d2 : d2;
    vline = ((cx_q >= 10'd1) && (ox_q <= LH_L)) ||
            ((cx_q + 10'd2 <= COLS_L) && (ox_q >= XL_HI));
    hline = ((cy_q >= 10'd1) && (oy_q <= LH_L)) ||
            ((cy_q + 10'd2 <= ROWS_L) && (oy_q >= YL_HI));
    s2_en_d    = s1_en_q;
    s2_blank_d = s1_blank_q;
    s2_oog_d   = !((cx_q < COLS_L) && (cy_q < ROWS_L));
    s2_cur_d   = (adx <= CUR_L) && (ady <= CUR_L);
    s2_line_d  = vline | hline;
    s2_cross_d = (a1 < TW_S) || (a2 < TW_S);
    s2_frame_d = (ox_q < CT_L) || (ox_q >= XF_HI) || (oy_q < CT_L) || (oy_q >= YF_HI);
  end

  // stage-2 registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_en_q <= 1'b0; s2_blank_q <= 1'b0; s2_oog_q <= 1'b0; s2_cur_q <= 1'b0;
      s2_line_q <= 1'b0; s2_cross_q <= 1'b0; s2_frame_q <= 1'b0;
    end else begin
      s2_en_q <= s2_en_d; s2_blank_q <= s2_blank_d; s2_oog_q <= s2_oog_d; s2_cur_q <= s2_cur_d;
      s2_line_q <= s2_line_d; s2_cross_q <= s2_cross_d; s2_frame_q <= s2_frame_d;
    end
  end

  // pixel composition: cursor over grid line over cell shape over background
  always_comb begin
    shape   = SHAPE[2*status_in +: 2];
    pal     = PALETTE[12*status_in +: 12];
    color_d = BG_COLOR;
    if (!s2_en_q) begin
      color_d = 12'h000;
    end else if (s2_blank_q) begin
      color_d = BG_COLOR;
    end else if (s2_cur_q) begin
      color_d = CUR_COLOR;
    end else if (s2_oog_q) begin
      color_d = BG_COLOR;
    end else if (s2_line_q) begin
      color_d = LINE_COLOR;
    end else begin
      case (shape)
        2'd1:    color_d = pal;
        2'd2:    color_d = s2_cross_q ? pal : BG_COLOR;
        2'd3:    color_d = s2_frame_q ? pal : BG_COLOR;
        default: color_d = BG_COLOR;
      endcase
    end
  end

  // output pixel register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) color_q <= '0;
    else           color_q <= color_d;
  end

  assign color_out    = color_q;
  assign cell_x_out   = cell_x_q;
  assign cell_y_out   = cell_y_q;
  assign sync_err_out = err_q;

endmodule
